// File: rtl/ahb_arbiter_slave_pkg.sv
// Shared AHB definitions for the slave-port arbiter: HTRANS encodings and
// the arbiter FSM state type.
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ahb_arbiter_slave_rr_picker.sv
// Combinational round-robin search: first set request bit starting at
// (ptr + 1) mod N, wrapping so that the pointer position itself is tried last.
module ahb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          found_o
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (!found_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_slave.sv
// AHB slave-port arbiter: round-robin address-phase grant with burst hold,
// plus a data-phase select that trails the address phase by one completed beat.
module ahb_arbiter_slave
  import AHB_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  localparam int IW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [CHANNEL_NUM-1:0]      req,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      sel_addr,
  output logic [CHANNEL_NUM-1:0]      sel_data,
  output logic [IW-1:0]               hmaster,
  output logic                        grant_valid,
  output arb_state_e                  dbg_state_o
);

  arb_state_e             state_q;
  logic [CHANNEL_NUM-1:0] sel_addr_q;
  logic [CHANNEL_NUM-1:0] sel_data_q;
  logic [IW-1:0]          hmaster_q;
  logic                   grant_valid_q;
  logic [IW-1:0]          rr_ptr_q;

  logic [CHANNEL_NUM-1:0] qual;
  logic [CHANNEL_NUM-1:0] pick_grant;
  logic                   pick_found;
  logic [IW-1:0]          pick_idx;
  logic                   hold_burst;

  // An IDLE transfer type is not a real request even with req raised.
  always_comb begin
    qual = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      qual[i] = req[i] && (htrans[i] != HTRANS_IDLE);
    end
  end

  // Only the exact SEQ/BUSY codes keep the grant; anything else re-arbitrates.
  assign hold_burst = (state_q == ARB_OWNED) && req[hmaster_q] &&
                      ((htrans[hmaster_q] == HTRANS_SEQ) ||
                       (htrans[hmaster_q] == HTRANS_BUSY));

  ahb_rr_picker #(
    .N  (CHANNEL_NUM),
    .IW (IW)
  ) u_picker (
    .req_i   (qual),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .found_o (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (pick_grant[i]) pick_idx = IW'(i);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ARB_IDLE;
      sel_addr_q    <= '0;
      sel_data_q    <= '0;
      hmaster_q     <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= IW'(CHANNEL_NUM - 1);
    end else if (hready) begin
      sel_data_q <= sel_addr_q;
      if (hold_burst) begin
        state_q <= ARB_OWNED;
      end else if (pick_found) begin
        state_q       <= ARB_OWNED;
        sel_addr_q    <= pick_grant;
        hmaster_q     <= pick_idx;
        grant_valid_q <= 1'b1;
        rr_ptr_q      <= pick_idx;
      end else begin
        state_q       <= ARB_IDLE;
        sel_addr_q    <= '0;
        hmaster_q     <= '0;
        grant_valid_q <= 1'b0;
      end
    end
  end

  assign sel_addr    = sel_addr_q;
  assign sel_data    = sel_data_q;
  assign hmaster     = hmaster_q;
  assign grant_valid = grant_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Directed bench for ahb_arbiter_slave with two masters; expected values are
// hand-computed per step.
module tb_ahb_arbiter_slave;
  import AHB_package::*;

  logic            HCLK;
  logic            HRESETn;
  logic [1:0]      req;
  logic [1:0][1:0] htrans;
  logic            hready;
  logic [1:0]      sel_addr;
  logic [1:0]      sel_data;
  logic [0:0]      hmaster;
  logic            grant_valid;
  arb_state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  ahb_arbiter_slave #(.CHANNEL_NUM(2)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .req         (req),
    .htrans      (htrans),
    .hready      (hready),
    .sel_addr    (sel_addr),
    .sel_data    (sel_data),
    .hmaster     (hmaster),
    .grant_valid (grant_valid),
    .dbg_state_o (dbg_state)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output; the address-phase outputs must stay mutually consistent.
  task automatic chk(input string tag, input logic [1:0] ea, input logic [1:0] ed);
    logic [7:0] em;
    logic [7:0] ev;
    logic [7:0] es;
    em = (ea == 2'b10) ? 8'd1 : 8'd0;
    ev = (ea != 2'b00) ? 8'd1 : 8'd0;
    es = (ea != 2'b00) ? 8'(ARB_OWNED) : 8'(ARB_IDLE);
    check({tag, ".sel_addr"}, 8'(sel_addr), 8'(ea));
    check({tag, ".sel_data"}, 8'(sel_data), 8'(ed));
    check({tag, ".hmaster"}, 8'(hmaster), em);
    check({tag, ".grant_valid"}, 8'(grant_valid), ev);
    check({tag, ".state"}, 8'(dbg_state), es);
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] t1, input logic [1:0] t0, input logic rdy);
    req       = r;
    htrans[1] = t1;
    htrans[0] = t0;
    hready    = rdy;
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(2'b00, HTRANS_IDLE, HTRANS_IDLE, 1'b1);
    #22;
    chk("reset", 2'b00, 2'b00);
    HRESETn = 1'b1;

    // Idle bus: nothing granted.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", 2'b00, 2'b00);
    end

    // Contention alternates starting from master 0.
    drive(2'b11, HTRANS_NONSEQ, HTRANS_NONSEQ, 1'b1);
    step(); chk("cont1", 2'b01, 2'b00);
    step(); chk("cont2", 2'b10, 2'b01);
    step(); chk("cont3", 2'b01, 2'b10);
    step(); chk("cont4", 2'b10, 2'b01);

    // Wait states freeze everything.
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait", 2'b10, 2'b01);
    end
    hready = 1'b1;
    step(); chk("wait_resume", 2'b01, 2'b10);

    // Master 1 bursts: NONSEQ then three SEQ beats while master 0 waits.
    drive(2'b11, HTRANS_NONSEQ, HTRANS_NONSEQ, 1'b1);
    step(); chk("burst_b1", 2'b10, 2'b01);
    htrans[1] = HTRANS_SEQ;
    step(); chk("burst_b2", 2'b10, 2'b10);
    step(); chk("burst_b3", 2'b10, 2'b10);
    step(); chk("burst_b4", 2'b10, 2'b10);
    drive(2'b01, HTRANS_IDLE, HTRANS_NONSEQ, 1'b1);
    step(); chk("burst_end", 2'b01, 2'b10);

    // BUSY keeps master 0 owning despite master 1 asking.
    drive(2'b11, HTRANS_NONSEQ, HTRANS_BUSY, 1'b1);
    step(); chk("busy1", 2'b01, 2'b01);
    step(); chk("busy2", 2'b01, 2'b01);

    // req high with IDLE htrans is not a qualified request.
    drive(2'b11, HTRANS_NONSEQ, HTRANS_IDLE, 1'b1);
    step(); chk("unqual", 2'b10, 2'b01);

    // Undefined owner htrans must not hold the grant.
    drive(2'b11, 2'bxx, HTRANS_NONSEQ, 1'b1);
    step(); chk("x_htrans", 2'b01, 2'b10);

    // No requesters: drop to IDLE, zero select then flows into data phase.
    drive(2'b00, HTRANS_IDLE, HTRANS_IDLE, 1'b1);
    step(); chk("drop_idle", 2'b00, 2'b01);
    step(); chk("idle_data0", 2'b00, 2'b00);

    // Lone requester is re-granted back-to-back.
    drive(2'b10, HTRANS_NONSEQ, HTRANS_IDLE, 1'b1);
    step(); chk("lone1", 2'b10, 2'b00);
    step(); chk("lone2", 2'b10, 2'b10);

    // Reset mid-burst clears outputs without waiting for a clock edge.
    drive(2'b11, HTRANS_SEQ, HTRANS_NONSEQ, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("async_rst", 2'b00, 2'b00);
    step();
    chk("rst_hold", 2'b00, 2'b00);
    #2;
    drive(2'b11, HTRANS_NONSEQ, HTRANS_NONSEQ, 1'b1);
    HRESETn = 1'b1;
    step(); chk("post_rst", 2'b01, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_slave.md
AHB_ARBITER_SLAVE -- requirements
Module: ahb_arbiter_slave

Interface
REQ-001 Parameter CHANNEL_NUM, default 2; number of masters that can reach this slave port.
REQ-002 Port HCLK  in  1  single clock for all state.
REQ-003 Port HRESETn  in  1  reset; asynchronous assert, active-low.
REQ-004 Port req  in  CHANNEL_NUM  bit i = master i has a pending transfer decoded to this slave.
REQ-005 Port htrans  in  CHANNEL_NUM x 2  pending HTRANS of each master, AHB encoding.
REQ-006 Port hready  in  1  slave HREADYOUT; 1 = current address/data phase completes this cycle.
REQ-007 Port sel_addr  out  CHANNEL_NUM  one-hot or zero; address-phase select for the slave payload mux.
REQ-008 Port sel_data  out  CHANNEL_NUM  one-hot or zero; data-phase select for the write-data and response path.
REQ-009 Port hmaster  out  $clog2(CHANNEL_NUM)  index of the address-phase owner; 0 when there is no owner.
REQ-010 Port grant_valid  out  1  1 when sel_addr is non-zero.

Function
REQ-011 sel_addr, sel_data, hmaster and grant_valid shall come directly from registers, with no combinational path from inputs.
REQ-012 FSM states: IDLE (no owner, sel_addr = 0) and OWNED (exactly one sel_addr bit set).
REQ-013 Arbitration decision: taken only in a cycle with hready = 1; with hready = 0, all state and outputs hold.
REQ-014 Burst hold: in OWNED with hready = 1, if req[owner] = 1 and htrans[owner] is SEQ or BUSY, the owner keeps the grant regardless of other requests.
REQ-015 Re-arbitration, all other hready = 1 cycles: grant the first requesting master in round-robin order from (last owner + 1) mod CHANNEL_NUM; enter OWNED.
REQ-016 Request qualification: a master counts as requesting only if req = 1 and its htrans is not IDLE.
REQ-017 Round-robin order includes the last owner last, so a lone requester is re-granted back-to-back.
REQ-018 No qualified requester: go to IDLE, sel_addr = 0; the round-robin pointer keeps the last owner.
REQ-019 Grant latency: a request seen at a hready = 1 edge gives sel_addr one cycle later; minimum arbitration latency is 1 cycle.
REQ-020 Data phase: on each hready = 1 edge, sel_data shall load the current sel_addr, so it lags the address phase by one completed phase.
REQ-021 Data phase hold: sel_data shall hold while hready = 0.
REQ-022 Zero select: an IDLE address phase shall load sel_data = 0.
REQ-023 Output consistency: hmaster shall always equal the index of the sel_addr bit, and grant_valid shall equal |sel_addr.
REQ-024 Unknown owner htrans: X or undefined htrans shall never be used to hold the grant; only the SEQ and BUSY encodings hold it.

Reset
REQ-025 On HRESETn low, asynchronously set: FSM = IDLE, sel_addr = 0, sel_data = 0, hmaster = 0, grant_valid = 0, round-robin pointer = CHANNEL_NUM-1 (master 0 highest priority first).
REQ-026 Reset mid-burst shall abandon ownership immediately; after release, arbitration restarts at the first hready = 1 edge.

Structure
REQ-027 The HTRANS encoding constants (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11) and the FSM state enum shall live in AHB_package.
REQ-028 The round-robin search shall be one combinational sub-module, ahb_rr_picker (inputs: request vector and pointer; outputs: one-hot grant and found flag), instantiated once.
REQ-029 sel_addr shall feed the slave-side payload mux select, and sel_data the response and write-data select, without further logic.

Verification
REQ-030 Reset then idle: hready = 1, req = 00 for 5 cycles -> sel_addr = 00, sel_data = 00, grant_valid = 0 throughout.
REQ-031 Contention: req = 11, htrans = NONSEQ for both, hready = 1 continuously -> sel_addr = 01, 10, 01, 10 on consecutive cycles; sel_data follows one cycle behind.
REQ-032 Burst hold: master 1 owns with htrans = SEQ for 4 beats while master 0 requests NONSEQ -> sel_addr = 10 for all 4 beats, then 01.
REQ-033 Wait states: hready = 0 for 3 cycles during contention -> sel_addr and sel_data frozen for those 3 cycles; arbitration resumes on the next hready = 1.
REQ-034 BUSY inside a burst: owner htrans = BUSY for 2 cycles with another requester present -> the grant is retained.
REQ-035 Reset mid-burst: HRESETn asserted while sel_addr = 10 -> all outputs 0 in the same cycle; after release with req = 11, the first grant is 01.
